// File: rtl/serial_add_arbiter.sv
// Round-robin front end for a shared bit-serial adder: grants one requester,
// captures its operands, adds LSB-first over WIDTH clocks and returns sum, carry and id.
module serial_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_found;
  logic [ID_W-1:0]  w_win;
  int               w_best;
  int               w_dist;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_nxt;

  // Priority is the distance from pointer+1 going upward; smallest distance wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_best  = 0;
    w_dist  = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
      if (req[j] && (!w_found || w_dist < w_best)) begin
        w_found = 1'b1;
        w_best  = w_dist;
        w_win   = ID_W'(j);
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win == ID_W'(j)) begin
        w_a = a_in[j*WIDTH +: WIDTH];
        w_b = b_in[j*WIDTH +: WIDTH];
      end
    end
  end

  assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c       = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_sum_nxt = {w_s, r_sum[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= ID_W'(NUM_REQ-1);
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_id    <= w_win;
            r_ptr   <= w_win;
            gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= w_sum_nxt;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            rsp_sum   <= w_sum_nxt;
            rsp_cout  <= w_c;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: event-scheduled reference model compared every
// cycle, directed scenarios pinned with literal results, then random traffic.
module tb_serial_add_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] a_in = '0;
  logic [NUM_REQ*WIDTH-1:0] b_in = '0;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic                     rsp_valid;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic [ID_W-1:0]          rsp_id;

  serial_add_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  // Reference model: a grant schedules its result WIDTH edges later; arbitration
  // reopens on the edge after the result.
  logic [NUM_REQ-1:0] e_gnt = '0;
  logic               e_busy = 1'b0, e_valid = 1'b0, e_cout = 1'b0;
  logic [WIDTH-1:0]   e_sum = '0;
  logic [ID_W-1:0]    e_id = '0;
  int m_ptr = NUM_REQ-1, m_free = 0, m_due = -1, mcyc = 0, m_w, m_idx, m_mid;
  logic [WIDTH:0]     m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_gnt = '0; e_busy = 0; e_valid = 0; e_sum = '0; e_cout = 0; e_id = '0;
      m_ptr = NUM_REQ-1; m_free = 0; m_due = -1;
    end else begin
      mcyc++;
      e_gnt = '0; e_valid = 0;
      if (mcyc == m_due) begin
        e_valid = 1; e_sum = m_full[WIDTH-1:0]; e_cout = m_full[WIDTH];
        e_id = ID_W'(m_mid); e_busy = 0; m_free = mcyc + 1;
      end
      if (mcyc >= m_free && req != '0) begin
        m_w = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          m_idx = (m_ptr + k) % NUM_REQ;
          if (m_w < 0 && req[m_idx]) m_w = m_idx;
        end
        e_gnt[m_w] = 1'b1; e_busy = 1; m_ptr = m_w; m_mid = m_w;
        m_full = {1'b0, a_in[m_w*WIDTH +: WIDTH]} + {1'b0, b_in[m_w*WIDTH +: WIDTH]};
        m_due = mcyc + WIDTH; m_free = 32'h7fffffff;
      end
    end
  end

  int checks = 0, errors = 0, tcyc = 0;
  logic [NUM_REQ-1:0] drop_mask = '1;
  logic [WIDTH-1:0] rq_sum[$];
  logic             rq_cout[$];
  int               rq_id[$], rq_cyc[$], gq_id[$], gq_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, tcyc);
    end
  endtask

  // One clock: compare all outputs against the model, log events, drop granted reqs.
  task automatic step();
    @(negedge clk);
    tcyc++;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
    chk("rsp_sum", 32'(rsp_sum), 32'(e_sum));
    chk("rsp_cout", 32'(rsp_cout), 32'(e_cout));
    chk("rsp_id", 32'(rsp_id), 32'(e_id));
    if (rsp_valid) begin
      rq_sum.push_back(rsp_sum); rq_cout.push_back(rsp_cout);
      rq_id.push_back(int'(rsp_id)); rq_cyc.push_back(tcyc);
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin gq_id.push_back(i); gq_cyc.push_back(tcyc); end
    req = req & ~(gnt & drop_mask);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int k;
    k = 0;
    while (rq_sum.size() < n && k < 400) begin step(); k++; end
    chk({nm, "_arrived"}, 32'(rq_sum.size() >= n), 32'd1);
  endtask

  task automatic wait_gnt(input int n);
    int k;
    k = 0;
    while (gq_id.size() < n && k < 400) begin step(); k++; end
    chk("gnt_arrived", 32'(gq_id.size() >= n), 32'd1);
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
    req[i] = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return '1;
      1: return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  int rb, gb, t0;

  initial begin
    rst_n = 1'b0;
    steps(3);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sum", 32'(rsp_sum), 32'd0);
    #2 rst_n = 1'b1;
    step();

    // 1: basic add, grant latency and result latency
    rb = rq_sum.size(); gb = gq_id.size(); t0 = tcyc;
    set_req(0, 16'h1234, 16'h4321);
    wait_rsp(rb + 1, "t1");
    if (rq_sum.size() > rb && gq_id.size() > gb) begin
      chk("t1_sum", 32'(rq_sum[rb]), 32'h5555);
      chk("t1_cout", 32'(rq_cout[rb]), 32'd0);
      chk("t1_id", rq_id[rb], 0);
      chk("t1_gnt_lat", gq_cyc[gb] - t0, 1);
      chk("t1_rsp_lat", rq_cyc[rb] - gq_cyc[gb], 16);
    end
    steps(2);

    // 2: carry out, sum wraps
    rb = rq_sum.size();
    set_req(2, 16'hFFFF, 16'h0001);
    wait_rsp(rb + 1, "t2a");
    set_req(2, 16'h8000, 16'h8000);
    wait_rsp(rb + 2, "t2b");
    if (rq_sum.size() > rb + 1) begin
      chk("t2a_sum", 32'(rq_sum[rb]), 32'h0);
      chk("t2a_cout", 32'(rq_cout[rb]), 32'd1);
      chk("t2a_id", rq_id[rb], 2);
      chk("t2b_sum", 32'(rq_sum[rb+1]), 32'h0);
      chk("t2b_cout", 32'(rq_cout[rb+1]), 32'd1);
    end
    steps(2);

    // 3: all four requesters at once (pointer now 2, so re-reset to start at 0)
    #2 rst_n = 1'b0;
    step();
    #2 rst_n = 1'b1;
    rb = rq_sum.size(); gb = gq_id.size();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, WIDTH'(i), 16'h0100);
    wait_rsp(rb + 4, "t3");
    if (rq_sum.size() >= rb + 4 && gq_id.size() >= gb + 4)
      for (int i = 0; i < 4; i++) begin
        chk("t3_gnt_order", gq_id[gb+i], i);
        chk("t3_id", rq_id[rb+i], i);
        chk("t3_sum", 32'(rq_sum[rb+i]), 32'h0100 + 32'(i));
        if (i > 0) chk("t3_gnt_gap", gq_cyc[gb+i] - gq_cyc[gb+i-1], 17);
      end
    steps(2);

    // 4: fairness with 1 and 3 held high
    gb = gq_id.size(); rb = rq_sum.size();
    drop_mask = 4'b0101;
    set_req(1, 16'h0011, 16'h0022);
    set_req(3, 16'h0033, 16'h0044);
    wait_rsp(rb + 4, "t4");
    if (gq_id.size() >= gb + 4) begin
      chk("t4_g0", gq_id[gb], 1);
      chk("t4_g1", gq_id[gb+1], 3);
      chk("t4_g2", gq_id[gb+2], 1);
      chk("t4_g3", gq_id[gb+3], 3);
    end
    req = '0; drop_mask = '1;
    steps(20);

    // 6: request during SHIFT withdrawn; operand change after grant ignored
    gb = gq_id.size(); rb = rq_sum.size();
    set_req(0, 16'h0010, 16'h0020);
    wait_gnt(gb + 1);
    a_in[0 +: WIDTH] = 16'hFFFF; b_in[0 +: WIDTH] = 16'h0000;
    steps(2);
    req[1] = 1'b1;
    steps(5);
    req[1] = 1'b0;
    wait_rsp(rb + 1, "t6");
    if (rq_sum.size() > rb) chk("t6_sum", 32'(rq_sum[rb]), 32'h0030);
    steps(4);
    chk("t6_no_gnt1", gq_id.size() - gb, 1);

    // 5: reset mid-operation, then 0 wins over 2
    gb = gq_id.size(); rb = rq_sum.size();
    set_req(1, 16'h00FF, 16'h0001);
    wait_gnt(gb + 1);
    steps(8);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    req = '0;
    set_req(0, 16'h0003, 16'h0003);
    set_req(2, 16'h0007, 16'h0007);
    steps(2);
    #2 rst_n = 1'b1;
    gb = gq_id.size();
    wait_rsp(rb + 2, "t5");
    if (rq_sum.size() >= rb + 2 && gq_id.size() > gb) begin
      chk("t5_first_gnt", gq_id[gb], 0);
      chk("t5_id0", rq_id[rb], 0);
      chk("t5_sum0", 32'(rq_sum[rb]), 32'h0006);
      chk("t5_id1", rq_id[rb+1], 2);
      chk("t5_sum1", 32'(rq_sum[rb+1]), 32'h000E);
    end
    steps(4);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drop_mask = ($urandom_range(0, 3) == 0) ? NUM_REQ'($urandom) : '1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) set_req(i, rnd_op(), rnd_op());
        end else if ($urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
      end
      step();
    end
    req = '0;
    steps(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
